// File: rtl/mips_isa_pkg.sv
// MIPS opcode/funct constants, op-select codes and encoder FSM states shared by
// the encoder, the decoder and the testbenches.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;

  typedef enum logic [3:0] {
    OPS_ADD  = 4'd0,
    OPS_SUB  = 4'd1,
    OPS_AND  = 4'd2,
    OPS_OR   = 4'd3,
    OPS_SLL  = 4'd4,
    OPS_SLLV = 4'd5,
    OPS_SRAV = 4'd6,
    OPS_LW   = 4'd7,
    OPS_SW   = 4'd8,
    OPS_BEQ  = 4'd9,
    OPS_ADDI = 4'd10,
    OPS_J    = 4'd11
  } op_sel_e;

  typedef enum logic [1:0] {
    ENC_IDLE,
    ENC_LOAD,
    ENC_DONE
  } enc_state_e;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt,
                                        input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packer: op select plus register/immediate fields to one 32-bit
// MIPS word; op codes 12..15 produce a NOP word and raise illegal.
module instr_word_pack
  import mips_isa_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OPS_ADD:  word = rtype(rs, rt, rd, 5'd0, FN_ADD);
      OPS_SUB:  word = rtype(rs, rt, rd, 5'd0, FN_SUB);
      OPS_AND:  word = rtype(rs, rt, rd, 5'd0, FN_AND);
      OPS_OR:   word = rtype(rs, rt, rd, 5'd0, FN_OR);
      OPS_SLL:  word = rtype(5'd0, rt, rd, shamt, FN_SLL);
      OPS_SLLV: word = rtype(rs, rt, rd, 5'd0, FN_SLLV);
      OPS_SRAV: word = rtype(rs, rt, rd, 5'd0, FN_SRAV);
      OPS_LW:   word = itype(OP_LW, rs, rt, imm);
      OPS_SW:   word = itype(OP_SW, rs, rt, imm);
      OPS_BEQ:  word = itype(OP_BEQ, rs, rt, imm);
      OPS_ADDI: word = itype(OP_ADDI, rs, rt, imm);
      OPS_J:    word = {OP_J, target};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Load-session FSM that packs instruction requests and writes them to IMEM.
// Optional IENC_ILLEGAL_CHECK_EN: drop op 12..15 and flag them on err_illegal.
module instr_stream_encoder
  import mips_isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [3:0]                    in_op,
  input  logic [4:0]                    in_rs,
  input  logic [4:0]                    in_rt,
  input  logic [4:0]                    in_rd,
  input  logic [4:0]                    in_shamt,
  input  logic [15:0]                   in_imm,
  input  logic [25:0]                   in_target,
  output logic                          imem_we,
  output logic [31:0]                   imem_addr,
  output logic [31:0]                   imem_wdata,
  output logic [$clog2(IMEM_WORDS):0]   word_count,
  output logic                          done,
`ifdef IENC_ILLEGAL_CHECK_EN
  output logic                          err_illegal,
`endif
  output logic                          overflow
);

  localparam int unsigned CW = $clog2(IMEM_WORDS) + 1;

  enc_state_e  state;
  logic [31:0] next_addr;
  logic [31:0] word;
  logic        illegal;
  logic        accept;
  logic        drop;
  logic        do_write;
  logic        last_slot;

  instr_word_pack u_pack (
    .op      (in_op),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .imm     (in_imm),
    .target  (in_target),
    .word    (word),
    .illegal (illegal)
  );

`ifdef IENC_ILLEGAL_CHECK_EN
  assign drop = illegal;
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
  assign drop = 1'b0;
`endif

  assign in_ready  = (state == ENC_LOAD) && (word_count < CW'(IMEM_WORDS));
  assign accept    = in_valid && in_ready;
  assign do_write  = accept && !drop;
  assign last_slot = (word_count == CW'(IMEM_WORDS - 1));
  assign done      = (state == ENC_DONE);

  // imem_addr holds the address of the word being written; next_addr runs one
  // word ahead so the output stage never waits on the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ENC_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      next_addr  <= BASE_ADDR;
      word_count <= '0;
      overflow   <= 1'b0;
`ifdef IENC_ILLEGAL_CHECK_EN
      err_illegal <= 1'b0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        ENC_IDLE: begin
          if (start) begin
            state      <= ENC_LOAD;
            word_count <= '0;
            next_addr  <= BASE_ADDR;
            imem_addr  <= BASE_ADDR;
            overflow   <= 1'b0;
`ifdef IENC_ILLEGAL_CHECK_EN
            err_illegal <= 1'b0;
`endif
          end
        end
        ENC_LOAD: begin
          if (accept) begin
            if (do_write) begin
              imem_we    <= 1'b1;
              imem_addr  <= next_addr;
              imem_wdata <= word;
              next_addr  <= next_addr + 32'd4;
              word_count <= word_count + CW'(1);
              if (last_slot && !in_last) overflow <= 1'b1;
            end
`ifdef IENC_ILLEGAL_CHECK_EN
            if (drop) err_illegal <= 1'b1;
`endif
            if (in_last || (do_write && last_slot)) state <= ENC_DONE;
          end
        end
        ENC_DONE: state <= ENC_IDLE;
        default:  state <= ENC_IDLE;
      endcase
    end
  end

endmodule
